// File: rtl/flit_link_tx_if.sv
// FIFO-side and link-side handshake bundle for the flit link transmitter.
// master = transmitter side, slave = FIFO/downstream side.
interface flit_link_tx_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_rd_en, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_rd_en, out_valid, out_data
  );
endinterface

// File: rtl/flit_link_tx.sv
// Router output-port link transmitter: pops a show-ahead FIFO, registers flits
// onto a valid/ready link, enforces wormhole framing and counts packets.
module flit_link_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  flit_link_tx_if.master       bus,
  input  logic                 err_clr,
  output logic                 in_packet,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic                 proto_err
);

  typedef enum logic {S_IDLE, S_BODY} state_t;
  typedef enum logic [1:0] {T_SINGLE = 2'b00, T_HEAD = 2'b01, T_BODY = 2'b10, T_TAIL = 2'b11} flit_t;

  state_t                state_q, state_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q;
  logic                  err_q;

  logic  slot_free, rd_en, legal, closes;
  flit_t ftype;

  assign ftype     = flit_t'(bus.fifo_dout[DATA_WIDTH-1 -: 2]);
  assign slot_free = ~out_valid_q | bus.out_ready;
  assign rd_en     = ~rst & ~bus.fifo_empty & slot_free;

  // Illegal flits never move the FSM; only a legal pop can change state.
  always_comb begin
    legal   = 1'b0;
    closes  = 1'b0;
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        legal  = (ftype == T_SINGLE) || (ftype == T_HEAD);
        closes = (ftype == T_SINGLE);
        if (rd_en && ftype == T_HEAD) state_d = S_BODY;
      end
      S_BODY: begin
        legal  = (ftype == T_BODY) || (ftype == T_TAIL);
        closes = (ftype == T_TAIL);
        if (rd_en && ftype == T_TAIL) state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pkt_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rd_en) begin
        if (legal) begin
          out_data_q  <= bus.fifo_dout;
          out_valid_q <= 1'b1;
          if (closes) pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // An illegal pop in the same cycle overrides the clear request.
      if (rd_en && !legal) err_q <= 1'b1;
      else if (err_clr)    err_q <= 1'b0;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign in_packet      = (state_q == S_BODY);
  assign pkt_count      = pkt_cnt_q;
  assign proto_err      = err_q;

endmodule
